// File: rtl/rgb_stream_pkg.sv
// Shared types and pixel layout for the RGB frame streamer and its result writer.
`timescale 1ns/1ps
package rgb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  localparam int PIX_W = 8;
  localparam int RGB_W = 3 * PIX_W;
  // Packed pixel is {R,G,B}, R in the top byte.
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

endpackage

// File: rtl/gray_result_writer.sv
// Captures converter results into the result RAM, counts them, and watches for
// overflow and for a converter that stops answering while the frame drains.
`timescale 1ns/1ps
module gray_result_writer #(
  parameter int N_PIXELS      = 496321,
  parameter int ADDR_W        = 19,
  parameter int GRAY_W        = 32,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture_en,
  input  logic              drain,
  input  logic              output_valid,
  input  logic [GRAY_W-1:0] gray,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [GRAY_W-1:0] wr_data,
  output logic              frame_written,
  output logic              timeout_hit,
  output logic              err_timeout,
  output logic              err_overflow
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  N_LAST    = CNT_W'(N_PIXELS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  logic [CNT_W-1:0]  res_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept;
  logic              spill;

  assign frame_written = (res_cnt == N_LAST);
  assign accept        = capture_en && output_valid && !frame_written;
  assign spill         = capture_en && output_valid && frame_written;
  // Fires on the last of DRAIN_TIMEOUT consecutive silent drain cycles.
  assign timeout_hit   = drain && !output_valid && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt      <= '0;
      idle_cnt     <= '0;
      wr_en        <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (clear) begin
      res_cnt      <= '0;
      idle_cnt     <= '0;
      wr_en        <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) res_cnt <= res_cnt + CNT_W'(1);
      if (!drain || output_valid) idle_cnt <= '0;
      else if (!timeout_hit)      idle_cnt <= idle_cnt + IDLE_W'(1);
      if (timeout_hit) err_timeout  <= 1'b1;
      if (spill)       err_overflow <= 1'b1;
    end
  end

  // Write port payload; cleared on reset so the port reads all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (accept) begin
      wr_addr <= res_cnt[ADDR_W-1:0];
      wr_data <= gray;
    end
  end

endmodule

// File: rtl/rgb_frame_streamer.sv
// Streams a frame of packed RGB pixels from the frame RAM into the gray converter
// and hands converter results to the result writer; signals done per frame.
`timescale 1ns/1ps
module rgb_frame_streamer
  import rgb_stream_pkg::*;
#(
  parameter int N_PIXELS      = 496321,
  parameter int ADDR_W        = 19,
  parameter int GRAY_W        = 32,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RGB_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  R,
  output logic [PIX_W-1:0]  G,
  output logic [PIX_W-1:0]  B,
  output logic              input_valid,
  input  logic              output_valid,
  input  logic [GRAY_W-1:0] GRAY,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [GRAY_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_overflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_PIXELS);

  stream_state_t    state, state_nxt;
  logic [CNT_W-1:0] send_cnt;
  logic             start_ok;
  logic             drain_act;
  logic             frame_written;
  logic             timeout_hit;
  logic             vld_p0, vld_p1;
  logic [PIX_W-1:0] r_p1, g_p1, b_p1;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign drain_act = (state == DRAIN);
  assign rd_addr   = send_cnt[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: begin
        busy  = 1'b1;
        rd_en = !pause && (send_cnt < N_LAST);
        if (send_cnt == N_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (frame_written || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = STREAM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           send_cnt <= '0;
    else if (start_ok) send_cnt <= '0;
    else if (rd_en)    send_cnt <= send_cnt + CNT_W'(1);
  end

  // p0: frame RAM read in flight; rd_data is valid while vld_p0 is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
    end
  end

  // p1: pixel registered toward the converter, held between valid beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1 <= '0;
      g_p1 <= '0;
      b_p1 <= '0;
    end else if (vld_p0) begin
      r_p1 <= rd_data[R_LSB +: PIX_W];
      g_p1 <= rd_data[G_LSB +: PIX_W];
      b_p1 <= rd_data[B_LSB +: PIX_W];
    end
  end

  assign input_valid = vld_p1;
  assign R = r_p1;
  assign G = g_p1;
  assign B = b_p1;

  gray_result_writer #(
    .N_PIXELS      (N_PIXELS),
    .ADDR_W        (ADDR_W),
    .GRAY_W        (GRAY_W),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_writer (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok),
    .capture_en    (busy),
    .drain         (drain_act),
    .output_valid  (output_valid),
    .gray          (GRAY),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_written (frame_written),
    .timeout_hit   (timeout_hit),
    .err_timeout   (err_timeout),
    .err_overflow  (err_overflow)
  );

endmodule
